data_array_ctrl: RTL and testbench

- Requester-side controller that owns the single-port 1024x32 data array.
- Accepts read/write requests from the cache pipeline on a valid/ready interface and drives the array's en/addr/wdata/wmode/wmask pins.
- Captures the array's 1-cycle-late read data in the exact cycle it is valid.
- Returns one in-order response per request (read data or write ack) through a credit-protected response FIFO, so downstream back-pressure never loses array data.

---
 rtl/data_array_ctrl.sv | 125 ++++++++++++
 tb/tb_data_array_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_array_ctrl.sv
// Requester-side controller for the single-port data array: issues accesses from a
// valid/ready request stream and returns in-order responses through a credit-guarded FIFO.
module data_array_ctrl #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              req_wmask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              arr_en,
    output logic [ADDR_W-1:0] arr_addr,
    output logic [DATA_W-1:0] arr_wdata,
    output logic              arr_wmode,
    output logic              arr_wmask,
    input  logic [DATA_W-1:0] arr_rdata,
    output logic              busy
);
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(RSP_DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_OCC = (CNT_W + 1)'(RSP_DEPTH);

    logic              ready_en_r;
    logic              s1_valid_r;
    logic              s1_write_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic              fifo_write_r [RSP_DEPTH];
    logic [DATA_W-1:0] fifo_rdata_r [RSP_DEPTH];
    logic [CNT_W:0]    occupancy_s;
    logic              handshake_s;
    logic              push_s;
    logic              pop_s;
    logic [DATA_W-1:0] capture_data_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? {PTR_W{1'b0}} : ptr + PTR_W'(1);
    endfunction

    // Credit check, issue decode and FIFO head presentation
    always_comb begin
        // Every request in S1 or the FIFO already owns a slot, so credit depends on registers only
        occupancy_s    = {{CNT_W{1'b0}}, s1_valid_r} + {1'b0, count_r};
        req_ready      = ready_en_r & (occupancy_s < DEPTH_OCC);
        handshake_s    = req_valid & req_ready;
        push_s         = s1_valid_r;
        rsp_valid      = (count_r != {CNT_W{1'b0}});
        pop_s          = rsp_valid & rsp_ready;
        capture_data_s = s1_write_r ? {DATA_W{1'b0}} : arr_rdata;
        busy           = s1_valid_r | rsp_valid;
        arr_en         = handshake_s;
        arr_addr       = req_addr;
        arr_wdata      = req_wdata;
        arr_wmode      = req_write;
        arr_wmask      = req_wmask;
        rsp_write      = fifo_write_r[rd_ptr_r];
        rsp_rdata      = fifo_rdata_r[rd_ptr_r];
    end

    // Holds off acceptance until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
        end
    end

    // S1: marks the cycle in which the array returns data for the issued access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_write_r <= 1'b0;
        end else begin
            s1_valid_r <= handshake_s;
            s1_write_r <= handshake_s ? req_write : s1_write_r;
        end
    end

    // Response FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Response FIFO storage; arr_rdata is only meaningful in the S1 cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                fifo_write_r[i] <= 1'b0;
                fifo_rdata_r[i] <= {DATA_W{1'b0}};
            end
        end else if (push_s) begin
            fifo_write_r[wr_ptr_r] <= s1_write_r;
            fifo_rdata_r[wr_ptr_r] <= capture_data_s;
        end
    end

endmodule

// File: tb/tb_data_array_ctrl.sv
// Bench for data_array_ctrl: directed test-plan steps plus random traffic checked
// against a memory + in-order queue reference and a behavioural single-port array.
module tb_data_array_ctrl;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_wmask;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_write;
    logic [31:0] rsp_rdata;
    logic        arr_en, arr_wmode, arr_wmask;
    logic [9:0]  arr_addr;
    logic [31:0] arr_wdata;
    logic [31:0] arr_rdata = 32'd0;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pops = 0;
    int hs = 0;
    logic ready_ok;
    logic        last_wr;
    logic [31:0] last_rd;

    typedef struct {
        logic        wr;
        logic [31:0] data;
        int          acc;
    } exp_t;
    exp_t exp_q[$];
    int   pop_log[$];
    logic [31:0] ref_mem [int];
    logic [31:0] arr_mem [int];

    data_array_ctrl #(.ADDR_W(10), .DATA_W(32), .RSP_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata),
        .arr_en(arr_en), .arr_addr(arr_addr), .arr_wdata(arr_wdata),
        .arr_wmode(arr_wmode), .arr_wmask(arr_wmask), .arr_rdata(arr_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] seed(input logic [9:0] a);
        return (32'h9E37_79B9 * {22'd0, a}) + 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Single-port array: writes land at the issue edge, read data lives for one cycle only
    always @(posedge clk) begin
        arr_rdata <= 32'd0;
        if (arr_en) begin
            if (arr_wmode) begin
                if (arr_wmask) arr_mem[int'(arr_addr)] = arr_wdata;
            end else begin
                arr_rdata <= arr_mem.exists(int'(arr_addr)) ? arr_mem[int'(arr_addr)] : seed(arr_addr);
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_ok <= 1'b0;
        else        ready_ok <= 1'b1;
    end

    // Reference: accepted-but-unreturned requests, each answered two cycles after its handshake cycle
    always @(negedge clk) begin
        logic exp_rdy, head_vis;
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_rsp_write", 32'(rsp_write), 32'd0);
            chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        end else begin
            exp_rdy  = ready_ok && (exp_q.size() < DEPTH);
            head_vis = (exp_q.size() > 0) && (cyc >= exp_q[0].acc + 2);
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("arr_en", 32'(arr_en), 32'(req_valid & exp_rdy));
            if (req_valid && exp_rdy) begin
                chk("arr_addr", 32'(arr_addr), 32'(req_addr));
                chk("arr_wmode", 32'(arr_wmode), 32'(req_write));
                if (req_write) begin
                    chk("arr_wdata", arr_wdata, req_wdata);
                    chk("arr_wmask", 32'(arr_wmask), 32'(req_wmask));
                end
            end
            chk("rsp_valid", 32'(rsp_valid), 32'(head_vis));
            chk("busy", 32'(busy), 32'(exp_q.size() != 0));
            if (head_vis) begin
                chk("rsp_write", 32'(rsp_write), 32'(exp_q[0].wr));
                chk("rsp_rdata", rsp_rdata, exp_q[0].data);
                if (rsp_ready) begin
                    last_wr = exp_q[0].wr;
                    last_rd = rsp_rdata;
                    void'(exp_q.pop_front());
                    pops++;
                    pop_log.push_back(cyc);
                end
            end
            if (req_valid && exp_rdy) begin
                e.wr  = req_write;
                e.acc = cyc;
                if (req_write) begin
                    e.data = 32'd0;
                    if (req_wmask) ref_mem[int'(req_addr)] = req_wdata;
                end else begin
                    e.data = ref_mem.exists(int'(req_addr)) ? ref_mem[int'(req_addr)] : seed(req_addr);
                end
                exp_q.push_back(e);
                hs++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic w, input logic [9:0] a, input logic [31:0] d, input logic m);
        logic took;
        int   n = 0;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wmask = m;
        do begin
            took = req_ready;
            step(1);
            n++;
        end while (!took && n < 50);
        chk("send_timeout", 32'(took), 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        while ((busy || exp_q.size() != 0) && n < 40) begin
            step(1);
            n++;
        end
        chk("drain_busy", 32'(busy), 32'd0);
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int idx;
        int p0;
        logic took;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 10'd0;
        req_wdata = 32'd0; req_wmask = 1'b0; rsp_ready = 1'b1;
        step(3);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);

        // Single write, back-to-back read, masked write, read
        send(1'b1, 10'h005, 32'hDEAD_BEEF, 1'b1);
        send(1'b0, 10'h005, 32'd0, 1'b0);
        step(3);
        chk("rd_after_wr_data", last_rd, 32'hDEAD_BEEF);
        chk("rd_after_wr_kind", 32'(last_wr), 32'd0);
        send(1'b1, 10'h005, 32'h1234_5678, 1'b0);
        send(1'b0, 10'h005, 32'd0, 1'b0);
        drain();
        chk("masked_wr_data", last_rd, 32'hDEAD_BEEF);

        // Back-pressure: only DEPTH requests fit while the consumer stalls
        rsp_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 10; c++) begin
            req_valid = (idx < 6); req_write = 1'b0; req_addr = 10'h3FC + 10'(idx);
            took = req_valid & req_ready;
            step(1);
            if (took) idx++;
        end
        chk("bp_accepted", 32'(idx), 32'd4);
        chk("bp_ready_low", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 6; c++) begin
            req_valid = 1'b1; req_write = 1'b0; req_addr = 10'h3FC + 10'(idx);
            took = req_ready;
            step(1);
            if (took) idx++;
        end
        req_valid = 1'b0;
        chk("bp_all_sent", 32'(idx), 32'd6);
        drain();
        chk("bp_last_data", last_rd, seed(10'h001));

        // Throughput: 16 reads on consecutive cycles, 16 consecutive responses
        pop_log.delete();
        for (int i = 0; i < 16; i++) begin
            chk("tput_ready", 32'(req_ready), 32'd1);
            send(1'b0, 10'(i * 37), 32'd0, 1'b0);
        end
        step(4);
        chk("tput_count", 32'(pop_log.size()), 32'd16);
        if (pop_log.size() == 16) chk("tput_span", 32'(pop_log[15] - pop_log[0]), 32'd15);
        drain();

        // Reset with S1 occupied and two FIFO entries
        rsp_ready = 1'b0;
        send(1'b0, 10'h010, 32'd0, 1'b0);
        send(1'b0, 10'h011, 32'd0, 1'b0);
        send(1'b0, 10'h012, 32'd0, 1'b0);
        chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
        chk("pre_rst_ready", 32'(req_ready), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_req_ready", 32'(req_ready), 32'd0);
        step(2);
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        step(3);
        p0 = pops;
        send(1'b0, 10'h005, 32'd0, 1'b0);
        drain();
        chk("post_rst_pops", 32'(pops - p0), 32'd1);
        chk("post_rst_data", last_rd, 32'hDEAD_BEEF);

        // Random traffic over a small address window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_write = 1'($urandom_range(0, 1));
            req_addr  = 10'($urandom_range(0, 7));
            req_wdata = $urandom;
            req_wmask = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            step(1);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
